// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch engine: default widths,
// default reset PC and the fetch FSM encoding.
package if_fetch_unit_pkg;

  localparam int DEF_ADDRESS_LEN     = 32;
  localparam int DEF_INSTRUCTION_LEN = 32;
  localparam logic [DEF_ADDRESS_LEN-1:0] DEF_RESET_PC = '0;

  // IDLE: may issue a request this cycle; WAIT: request outstanding, data
  // will be kept; DISCARD: request outstanding, data will be dropped.
  typedef enum logic [1:0] {
    IF_FETCH_IDLE    = 2'd0,
    IF_FETCH_WAIT    = 2'd1,
    IF_FETCH_DISCARD = 2'd2
  } if_fetch_state_e;

endpackage

// File: rtl/if_fetch_buffer.sv
// One-entry holding register between the instruction memory and the IF/ID
// register. Presents an all-zero bubble whenever it is empty.
module if_fetch_buffer
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDRESS_LEN     = DEF_ADDRESS_LEN,
  parameter int INSTRUCTION_LEN = DEF_INSTRUCTION_LEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       consume,
  input  logic                       clear,
  input  logic [ADDRESS_LEN-1:0]     load_pc4,
  input  logic [INSTRUCTION_LEN-1:0] load_instr,
  output logic                       buf_valid,
  output logic [ADDRESS_LEN-1:0]     pc_out,
  output logic [INSTRUCTION_LEN-1:0] instr_out
);

  logic [ADDRESS_LEN-1:0]     buf_pc4;
  logic [INSTRUCTION_LEN-1:0] buf_instr;

  // Entry update: a clear (redirect) beats a load, a load beats a consume
  // because a refill in the consume cycle leaves the entry full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_pc4   <= '0;
      buf_instr <= '0;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_pc4   <= load_pc4;
      buf_instr <= load_instr;
    end else if (consume) begin
      buf_valid <= 1'b0;
    end
  end

  // Bubble mux: an empty entry reads as the same zeros a flush would write.
  always_comb begin
    pc_out    = buf_valid ? buf_pc4   : '0;
    instr_out = buf_valid ? buf_instr : '0;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch engine: owns the PC, drives a req/ack instruction memory
// port with wait states, and feeds the IF/ID register through a one-entry
// buffer. Memory handshake: once imem_req rises with an address, req and
// addr stay constant until the cycle in which imem_ack is high; that cycle
// completes the transfer and imem_rdata is sampled at its closing edge.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDRESS_LEN     = DEF_ADDRESS_LEN,
  parameter int INSTRUCTION_LEN = DEF_INSTRUCTION_LEN,
  parameter logic [ADDRESS_LEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       branch_taken,
  input  logic [ADDRESS_LEN-1:0]     branch_address,
  output logic                       imem_req,
  output logic [ADDRESS_LEN-1:0]     imem_addr,
  input  logic                       imem_ack,
  input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
  output logic [ADDRESS_LEN-1:0]     PC_out,
  output logic [INSTRUCTION_LEN-1:0] instruction_out,
  output logic                       if_valid
);

  if_fetch_state_e        state;
  logic [ADDRESS_LEN-1:0] pc;
  logic [ADDRESS_LEN-1:0] discard_addr;
  logic [ADDRESS_LEN-1:0] pc4;
  logic                   buf_valid;
  logic                   consume;
  logic                   can_issue;
  logic                   load;

  // IF/ID takes the entry this edge; a new fetch may start if the entry
  // is or becomes free.
  always_comb begin
    consume   = buf_valid & ~freeze & ~branch_taken;
    can_issue = ~buf_valid | consume;
    pc4       = pc + ADDRESS_LEN'(4);
    load      = imem_req & imem_ack & ~branch_taken & (state != IF_FETCH_DISCARD);
  end

  // Memory port: requests are never withdrawn once raised, except by reset.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    case (state)
      IF_FETCH_IDLE:    imem_req = can_issue;
      IF_FETCH_WAIT:    imem_req = 1'b1;
      IF_FETCH_DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = discard_addr;
      end
      default:          imem_req = 1'b0;
    endcase
    if (rst) imem_req = 1'b0;
  end

  // PC and fetch FSM: a redirect always reloads the PC; an outstanding
  // request that is not acked in the redirect cycle is drained in DISCARD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IF_FETCH_IDLE;
      pc           <= RESET_PC;
      discard_addr <= RESET_PC;
    end else begin
      if (branch_taken)  pc <= branch_address;
      else if (load)     pc <= pc4;
      case (state)
        IF_FETCH_IDLE: begin
          if (imem_req && !imem_ack) begin
            if (branch_taken) begin
              state        <= IF_FETCH_DISCARD;
              discard_addr <= pc;
            end else begin
              state <= IF_FETCH_WAIT;
            end
          end
        end
        IF_FETCH_WAIT: begin
          if (imem_ack) begin
            state <= IF_FETCH_IDLE;
          end else if (branch_taken) begin
            state        <= IF_FETCH_DISCARD;
            discard_addr <= pc;
          end
        end
        IF_FETCH_DISCARD: begin
          if (imem_ack) state <= IF_FETCH_IDLE;
        end
        default: state <= IF_FETCH_IDLE;
      endcase
    end
  end

  if_fetch_buffer #(
    .ADDRESS_LEN     (ADDRESS_LEN),
    .INSTRUCTION_LEN (INSTRUCTION_LEN)
  ) u_buffer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .consume    (consume),
    .clear      (branch_taken),
    .load_pc4   (pc4),
    .load_instr (imem_rdata),
    .buf_valid  (buf_valid),
    .pc_out     (PC_out),
    .instr_out  (instruction_out)
  );

  assign if_valid = buf_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: each cycle the bench applies freeze /
// branch / ack, checks the request it expects, clocks, then checks outputs.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC_out;
  logic [31:0] instruction_out;
  logic        if_valid;

  int n_checks = 0;
  int n_pass   = 0;

  if_fetch_unit #(
    .ADDRESS_LEN     (32),
    .INSTRUCTION_LEN (32),
    .RESET_PC        (32'h0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_address  (branch_address),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .PC_out          (PC_out),
    .instruction_out (instruction_out),
    .if_valid        (if_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory image: address 0 holds the program's first instruction
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hE3A01005;
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic v);
    check({tag, ".pc"},    PC_out, pc);
    check({tag, ".instr"}, instruction_out, ins);
    check({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
  endtask

  // one cycle, started just after a falling edge, ends on the next one
  task automatic step(input string tag, input logic frz, input logic br, input logic [31:0] baddr,
                      input logic ack, input logic exp_req, input logic [31:0] exp_addr);
    freeze         = frz;
    branch_taken   = br;
    branch_address = baddr;
    imem_ack       = ack;
    imem_rdata     = ack ? mem_word(exp_addr) : 32'hBAD0BAD0;
    #1;
    check({tag, ".req"},  {31'd0, imem_req}, {31'd0, exp_req});
    check({tag, ".addr"}, imem_addr, exp_addr);
    @(posedge clk);
    @(negedge clk);
    freeze       = 1'b0;
    branch_taken = 1'b0;
    imem_ack     = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    freeze         = 1'b0;
    branch_taken   = 1'b0;
    branch_address = 32'h0;
    imem_ack       = 1'b0;
    imem_rdata     = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst.req", {31'd0, imem_req}, 32'd0);
    check("rst.addr", imem_addr, 32'h0);
    check_out("rst", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // zero-wait memory: back-to-back fetches 0, 4, 8
    step("z0", 0, 0, 0, 1, 1, 32'h0);
    check_out("z0", 32'h4, 32'hE3A01005, 1'b1);
    step("z1", 0, 0, 0, 1, 1, 32'h4);
    check_out("z1", 32'h8, mem_word(32'h4), 1'b1);
    step("z2", 0, 0, 0, 1, 1, 32'h8);
    check_out("z2", 32'hC, mem_word(32'h8), 1'b1);

    // two wait states at 0xC: request held, bubbles in the gap
    step("w0", 0, 0, 0, 0, 1, 32'hC);
    check_out("w0", 32'h0, 32'h0, 1'b0);
    step("w1", 0, 0, 0, 0, 1, 32'hC);
    check_out("w1", 32'h0, 32'h0, 1'b0);
    step("w2", 0, 0, 0, 1, 1, 32'hC);
    check_out("w2", 32'h10, mem_word(32'hC), 1'b1);

    // freeze three cycles with a full buffer: hold, no request
    for (int i = 0; i < 3; i++) begin
      step("frz", 1, 0, 0, 0, 0, 32'h10);
      check_out("frz", 32'h10, mem_word(32'hC), 1'b1);
    end
    step("unfrz", 0, 0, 0, 1, 1, 32'h10);
    check_out("unfrz", 32'h14, mem_word(32'h10), 1'b1);

    // branch to 0x100 while a fetch of 0x14 is waiting
    step("bw0", 0, 0, 0, 0, 1, 32'h14);
    check_out("bw0", 32'h0, 32'h0, 1'b0);
    step("bw1", 0, 1, 32'h100, 0, 1, 32'h14);
    check_out("bw1", 32'h0, 32'h0, 1'b0);
    step("disc0", 0, 0, 0, 0, 1, 32'h14);
    check_out("disc0", 32'h0, 32'h0, 1'b0);
    step("disc1", 0, 0, 0, 1, 1, 32'h14);
    check_out("disc1", 32'h0, 32'h0, 1'b0);
    step("tgt", 0, 0, 0, 1, 1, 32'h100);
    check_out("tgt", 32'h104, mem_word(32'h100), 1'b1);

    // branch to 0x200 with freeze: branch wins, buffer cleared
    step("bf", 1, 1, 32'h200, 0, 0, 32'h104);
    check_out("bf", 32'h0, 32'h0, 1'b0);
    step("bft", 0, 0, 0, 1, 1, 32'h200);
    check_out("bft", 32'h204, mem_word(32'h200), 1'b1);

    // PC wraps from 0xFFFFFFFC to 0
    step("bwrap", 0, 1, 32'hFFFFFFFC, 0, 0, 32'h204);
    check_out("bwrap", 32'h0, 32'h0, 1'b0);
    step("wrap", 0, 0, 0, 1, 1, 32'hFFFFFFFC);
    check_out("wrap", 32'h0, mem_word(32'hFFFFFFFC), 1'b1);

    // redirect to 0x40, start a waited fetch, then reset mid-wait
    step("b40", 0, 1, 32'h40, 0, 0, 32'h0);
    step("w40", 0, 0, 0, 0, 1, 32'h40);
    check_out("w40", 32'h0, 32'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst.req", {31'd0, imem_req}, 32'd0);
    check("arst.addr", imem_addr, 32'h0);
    check_out("arst", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step("rel", 0, 0, 0, 1, 1, 32'h0);
    check_out("rel", 32'h4, 32'hE3A01005, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
